// File: rtl/nand_sector_ecc.sv
// rtl/nand_sector_ecc.sv - Hamming SEC/DED parity generate/check engine for one NAND sector
// Accumulates column (bit) and line (byte index) parities; CALC turns them into parity and a verdict.
module nand_sector_ecc #(
    parameter int SECTOR_BYTES = 512,
    localparam int AW = $clog2(SECTOR_BYTES),
    localparam int ECC_W = 2 * (AW + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_check,
    input  logic [ECC_W-1:0] ecc_stored,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [ECC_W-1:0] ecc_out,
    output logic [1:0]       status,
    output logic [AW-1:0]    err_byte,
    output logic [2:0]       err_bit
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q;
    logic [AW-1:0]    lp1_q, lp0_q;
    logic [2:0]       cp1_q, cp0_q;
    logic             mode_q;
    logic [ECC_W-1:0] stored_q;

    logic             accept, last_byte, byte_par;
    logic [2:0]       cp1_t, cp0_t;
    logic [ECC_W-1:0] ecc_c, syn;
    logic [AW-1:0]    s_lp1, s_lp0;
    logic [2:0]       s_cp1, s_cp0;
    logic [1:0]       status_c;
    logic [AW-1:0]    err_byte_c;
    logic [2:0]       err_bit_c;

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (cnt_q == AW'(SECTOR_BYTES - 1));

    // Column masks select the bits whose position has bit k set (cp1) or clear (cp0).
    assign byte_par = ^in_data;
    assign cp1_t = {^(in_data & 8'hF0), ^(in_data & 8'hCC), ^(in_data & 8'hAA)};
    assign cp0_t = {^(in_data & 8'h0F), ^(in_data & 8'h33), ^(in_data & 8'h55)};

    assign ecc_c = {lp1_q, lp0_q, cp1_q, cp0_q};
    assign syn   = ecc_c ^ stored_q;
    assign s_lp1 = syn[ECC_W-1 -: AW];
    assign s_lp0 = syn[6 +: AW];
    assign s_cp1 = syn[5:3];
    assign s_cp0 = syn[2:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (last_byte) state_d = S_CALC;
            S_CALC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // A single flipped data bit makes each true/complement syndrome pair disagree everywhere.
    always_comb begin
        status_c   = 2'b00;
        err_byte_c = '0;
        err_bit_c  = '0;
        if (mode_q && (syn != '0)) begin
            if ((&(s_lp1 ^ s_lp0)) && (&(s_cp1 ^ s_cp0))) begin
                status_c   = 2'b01;
                err_byte_c = s_lp1;
                err_bit_c  = s_cp1;
            end else if ($onehot(syn)) begin
                status_c = 2'b10;
            end else begin
                status_c = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            lp1_q    <= '0;
            lp0_q    <= '0;
            cp1_q    <= '0;
            cp0_q    <= '0;
            mode_q   <= 1'b0;
            stored_q <= '0;
            ecc_out  <= '0;
            status   <= 2'b00;
            err_byte <= '0;
            err_bit  <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                cnt_q    <= '0;
                lp1_q    <= '0;
                lp0_q    <= '0;
                cp1_q    <= '0;
                cp0_q    <= '0;
                mode_q   <= mode_check;
                stored_q <= ecc_stored;
            end
            if (accept) begin
                cp1_q <= cp1_q ^ cp1_t;
                cp0_q <= cp0_q ^ cp0_t;
                lp1_q <= lp1_q ^ ({AW{byte_par}} & cnt_q);
                lp0_q <= lp0_q ^ ({AW{byte_par}} & ~cnt_q);
                cnt_q <= cnt_q + AW'(1);
            end
            if (state_q == S_CALC) begin
                ecc_out  <= ecc_c;
                status   <= status_c;
                err_byte <= err_byte_c;
                err_bit  <= err_bit_c;
            end
        end
    end
endmodule
